// File: rtl/vc_output_fifo_if.sv
// rtl/vc_output_fifo_if.sv - push/pop/status bundle between the referee, an output FIFO and its consumer
// The count signal exists only when VC_FIFO_COUNT_EN is defined.
interface vc_output_fifo_if #(
    parameter int LINE_SIZE = 12,
    parameter int PTR_W     = 3
);
    logic                 push;
    logic                 pop;
    logic [LINE_SIZE-1:0] data_in;
    logic [LINE_SIZE-1:0] data_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 error;
`ifdef VC_FIFO_COUNT_EN
    logic [PTR_W:0]       count;
`endif

    modport master (
        output push, pop, data_in,
        input  data_out, full, empty, almost_full, almost_empty, error
`ifdef VC_FIFO_COUNT_EN
        , input count
`endif
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, full, empty, almost_full, almost_empty, error
`ifdef VC_FIFO_COUNT_EN
        , output count
`endif
    );
endinterface

// File: rtl/vc_output_fifo.sv
// rtl/vc_output_fifo.sv - per-class output FIFO with a single fill counter and sticky error flag
// Optional VC_FIFO_COUNT_EN exposes the fill counter on the interface count signal.
module vc_output_fifo #(
    parameter int LINE_SIZE       = 12,
    parameter int DEPTH           = 8,
    parameter int PTR_W           = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic               clk,
    input  logic               reset,
    vc_output_fifo_if.slave    f
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(ALMOST_FULL_TH);
    localparam logic [PTR_W:0] AE_C    = (PTR_W+1)'(ALMOST_EMPTY_TH);

    logic [LINE_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [LINE_SIZE-1:0] data_out_q, data_out_d;
    logic                 error_q, error_d;
    logic                 full, empty, wr_en, rd_en;

    always_comb begin
        full       = (count_q == DEPTH_C);
        empty      = (count_q == '0);
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        wr_en      = f.push && (!full || f.pop);
        rd_en      = f.pop && !empty;
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        data_out_d = rd_en ? mem_q[rd_ptr_q] : data_out_q;
        error_d    = error_q | (f.push && full && !f.pop) | (f.pop && empty);
        count_d    = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    // Storage is not reset; the read above samples it before this write lands.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= f.data_in;
        end
    end

    assign f.data_out     = data_out_q;
    assign f.full         = full;
    assign f.empty        = empty;
    assign f.almost_full  = (count_q >= AF_C);
    assign f.almost_empty = (count_q <= AE_C);
    assign f.error        = error_q;
`ifdef VC_FIFO_COUNT_EN
    assign f.count        = count_q;
`endif
endmodule

// File: tb/tb_vc_output_fifo.sv
// tb/tb_vc_output_fifo.sv - directed bench for vc_output_fifo with a queue reference model
module tb_vc_output_fifo;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vc_output_fifo_if #(.LINE_SIZE(12), .PTR_W(3)) bus ();

    vc_output_fifo #(
        .LINE_SIZE(12), .DEPTH(8), .PTR_W(3), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .f     (bus.slave)
    );

    logic [11:0] m_q[$];
    logic [11:0] m_dout;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of stored words; a pop takes the head before any same-edge push joins.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_dout = '0;
            m_err  = 1'b0;
        end else begin
            automatic int  n = m_q.size();
            automatic bit  took = 0;
            if (bus.pop && n == 0) m_err = 1'b1;
            if (bus.push && n == 8 && !bus.pop) m_err = 1'b1;
            if (bus.pop && n > 0) begin
                m_dout = m_q.pop_front();
                took = 1;
            end
            if (bus.push && (m_q.size() < 8)) m_q.push_back(bus.data_in);
            if (took) ;
        end
    end

    always @(negedge clk) begin
        chk("cmp_data_out", bus.data_out, m_dout);
        chk("cmp_empty", bus.empty, m_q.size() == 0);
        chk("cmp_full", bus.full, m_q.size() == 8);
        chk("cmp_almost_full", bus.almost_full, m_q.size() >= 6);
        chk("cmp_almost_empty", bus.almost_empty, m_q.size() <= 2);
        chk("cmp_error", bus.error, m_err);
`ifdef VC_FIFO_COUNT_EN
        chk("cmp_count", bus.count, m_q.size());
`endif
    end

    task automatic step(input logic p, input logic q, input logic [11:0] d);
        @(negedge clk);
        bus.push = p;
        bus.pop = q;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_almost_empty", bus.almost_empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_almost_full", bus.almost_full, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_data_out", bus.data_out, 12'h000);
        @(negedge clk);
        reset = 1'b0;

        step(1, 0, 12'hDE4);
        step(1, 0, 12'h96C);
        step(1, 0, 12'h16E);
        step(0, 1, 12'h000); chk("t2_pop0", bus.data_out, 12'hDE4);
        step(0, 1, 12'h000); chk("t2_pop1", bus.data_out, 12'h96C);
        step(0, 1, 12'h000); chk("t2_pop2", bus.data_out, 12'h16E);
        chk("t2_empty", bus.empty, 1);

        for (int i = 0; i < 6; i++) begin
            step(1, 0, 12'h100 + 12'(i));
            if (i == 1) chk("t3_ae_after2", bus.almost_empty, 1);
            if (i == 2) chk("t3_ae_after3", bus.almost_empty, 0);
            if (i == 4) chk("t3_af_after5", bus.almost_full, 0);
            if (i == 5) chk("t3_af_after6", bus.almost_full, 1);
        end
        step(1, 0, 12'h106);
        chk("t3_full_after7", bus.full, 0);
        step(1, 0, 12'h107);
        chk("t3_full_after8", bus.full, 1);

        step(1, 0, 12'hABC);
        chk("t4_overflow_err", bus.error, 1);
        chk("t4_full_hold", bus.full, 1);
        step(1, 1, 12'h555);
        chk("t4_pushpop_head", bus.data_out, 12'h100);
        chk("t4_pushpop_full", bus.full, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 12'h000);
        chk("t4_drain_last", bus.data_out, 12'h555);
        chk("t4_drain_empty", bus.empty, 1);

        do_reset();
        chk("t5_rst_err", bus.error, 0);
        chk("t5_rst_dout", bus.data_out, 12'h000);
        step(1, 0, 12'h2A5);
        step(0, 1, 12'h000);
        chk("t5_read", bus.data_out, 12'h2A5);
        step(0, 1, 12'h000);
        chk("t5_underflow_err", bus.error, 1);
        chk("t5_underflow_hold", bus.data_out, 12'h2A5);
        do_reset();
        chk("t5_err_cleared", bus.error, 0);

        step(1, 1, 12'h333);
        chk("t5b_pp_empty_err", bus.error, 1);
        chk("t5b_pp_empty_notempty", bus.empty, 0);
        chk("t5b_pp_empty_dout", bus.data_out, 12'h000);
        do_reset();

        step(1, 0, 12'h7A0);
        step(1, 0, 12'h7A1);
        @(negedge clk);
        bus.push = 1'b1;
        bus.pop = 1'b0;
        bus.data_in = 12'h7FF;
        #3 reset = 1'b1;
        #1;
        chk("t_async_rst_empty", bus.empty, 1);
        chk("t_async_rst_dout", bus.data_out, 12'h000);
        bus.push = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;

        step(1, 0, 12'h300);
        step(1, 0, 12'h301);
        step(1, 0, 12'h302);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 12'h400 + 12'(i));
            if (i == 0) chk("t6_first", bus.data_out, 12'h300);
            if (i == 3) chk("t6_wrapped", bus.data_out, 12'h400);
            if (i == 19) begin
                chk("t6_last", bus.data_out, 12'h410);
                chk("t6_ae", bus.almost_empty, 0);
                chk("t6_af", bus.almost_full, 0);
                chk("t6_err", bus.error, 0);
            end
        end
        step(0, 0, 12'h000);
        step(0, 0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
